countdown_timer_core: RTL and testbench
=======================================

// Module: countdown_timer_core
// PURPOSE
//  Datapath for the egg timer, sitting downstream of the main control FSM.
//  - Holds the user-set MM:SS value and the running MM:SS countdown, both in BCD.
//  - Acts on the FSM's increment_*, prog_mode, load_timer and main_timer_enable strobes.
//  - Returns timer_done to the FSM, which uses it for the TIMER->DONE transition.
// PARAMETERS
//  MAX_MIN       59  highest settable minutes value (BCD-decoded range 0..99)
//  REPEAT_DELAY  4   rep_pulse strobes an increment must be held before auto-repeat starts
// PORTS
//  clk                input   1  system clock
//  reset_n            input   1  asynchronous reset, active low
//  sec_tick           input   1  one-cycle strobe, 1 Hz
//  rep_pulse          input   1  one-cycle strobe, auto-repeat rate (~4 Hz)
//  increment_seconds  input   1  level; button held while in cook-time mode
//  increment_minutes  input   1  level; same, for minutes
//  prog_mode          input   1  setting counters may change
//  load_timer         input   1  one-cycle strobe; copy setting into countdown
//  main_timer_enable  input   1  countdown may run
//  timer_done         output  1  sticky level; countdown is at 00:00 while enabled
//  done_pulse         output  1  one-cycle strobe on the 0->1 edge of timer_done
//  disp_min           output  8  BCD minutes: setting if prog_mode=1, else countdown
//  disp_sec           output  8  BCD seconds: same selection rule
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - set_min, set_sec, cur_min, cur_sec = 00; timer_done = 0; done_pulse = 0.
//   - Hold counters and edge registers are cleared.
//   - A reset mid-countdown or mid-hold aborts immediately; no partial state is kept.
//  Increment qualification (per channel; seconds and minutes are independent):
//   - One increment on the rising edge of increment_*, applied in the cycle after the edge.
//   - While the input stays high, count rep_pulse strobes.
//   - Once REPEAT_DELAY strobes are reached, each further rep_pulse gives one increment.
//   - Falling edge clears the hold count.
//   - Increments are applied only when prog_mode=1; otherwise they are ignored and not queued.
//  Setting counters:
//   - Seconds count 00..59 BCD and wrap to 00 with no carry into minutes.
//   - Minutes count 00..MAX_MIN and wrap to 00.
//   - Simultaneous seconds and minutes increments both take effect in the same cycle.
//   - The low BCD digit rolls 9->0 with the high digit +1; no invalid BCD code ever appears.
//  Countdown:
//   - load_timer=1: cur <= set and timer_done <= 0 next cycle.
//   - load_timer has priority over sec_tick in the same cycle.
//   - Decrement only when main_timer_enable=1, sec_tick=1, and cur != 00:00.
//   - SS=00 -> SS=59 with MM-1; otherwise SS-1 with a BCD borrow (x0 -> (x-1)9).
//   - At 00:00 the count holds; it never wraps to 99:59.
//  Done:
//   - timer_done sets in the cycle after cur==00:00 && main_timer_enable=1.
//   - This covers both arrival by decrement and enabling with 00:00 already loaded.
//   - It stays set until load_timer or reset.
//   - Out of reset the countdown is 00:00 and the FSM enables it, so DONE is reached.
//   - done_pulse is high for exactly one cycle when timer_done rises.
//  Outputs are registered except the disp_* mux, which is combinational on prog_mode.
// STRUCTURE
//  Shared package eggtimer_pkg holds:
//   - BCD_W=8, SEC_MAX=8'h59, default MAX_MIN;
//   - BCD increment/decrement functions, reused by the display driver.
//  Sub-module inc_repeater (edge detect plus REPEAT_DELAY hold counter), instantiated
//  twice, one per channel. Setting counters, countdown and done logic stay in the top.
// TESTING
//  - Reset release, prog_mode=1, one increment_seconds rising edge -> set_sec=01, disp_sec=8'h01.
//  - Set 00:59, +1 s -> 00:00 with minutes unchanged; minutes at MAX_MIN, +1 -> 00.
//  - Hold increment_minutes for 8 rep_pulse strobes, REPEAT_DELAY=4 -> set_min=05 (1 edge + 4 repeats).
//  - Set 01:00, load_timer, enable, one sec_tick -> 00:59; 59 more ticks -> 00:00; timer_done=1 next cycle; done_pulse one cycle.
//  - load_timer and sec_tick in the same cycle -> cur equals set exactly (no decrement); timer_done clears.
//  - Pull reset_n low mid-countdown at 00:30 -> all counters 00, timer_done=0 asynchronously.

Source files
------------

// File: rtl/countdown_timer_core_pkg.sv
// Shared egg-timer definitions: BCD widths/limits, repeater state encoding
// and BCD arithmetic helpers reused by the display driver.
package eggtimer_pkg;

    localparam int               BCD_W           = 8;
    localparam logic [BCD_W-1:0] SEC_MAX         = 8'h59;
    localparam int               MAX_MIN_DEFAULT = 59;

    typedef enum logic [1:0] {
        REP_IDLE,
        REP_HOLD,
        REP_REPEAT
    } rep_state_t;

    // Wraps to 00 at limit; otherwise +1 with a 9->0 carry into the tens digit.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v,
                                                 input logic [BCD_W-1:0] limit);
        if (v == limit) begin
            return '0;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // Saturates at 00; x0 borrows to (x-1)9.
    function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v);
        if (v == '0) begin
            return '0;
        end else if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end else begin
            return {v[7:4], v[3:0] - 4'd1};
        end
    endfunction

    function automatic logic [BCD_W-1:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

endpackage

// File: rtl/countdown_timer_core_if.sv
// Control/status bundle between the egg-timer FSM (master) and the
// countdown datapath (slave).
interface countdown_timer_core_if;
    import eggtimer_pkg::*;

    logic             increment_seconds;
    logic             increment_minutes;
    logic             prog_mode;
    logic             load_timer;
    logic             main_timer_enable;
    logic             timer_done;
    logic             done_pulse;
    logic [BCD_W-1:0] disp_min;
    logic [BCD_W-1:0] disp_sec;

    modport master (
        output increment_seconds, increment_minutes, prog_mode,
               load_timer, main_timer_enable,
        input  timer_done, done_pulse, disp_min, disp_sec
    );

    modport slave (
        input  increment_seconds, increment_minutes, prog_mode,
               load_timer, main_timer_enable,
        output timer_done, done_pulse, disp_min, disp_sec
    );

endinterface

// File: rtl/countdown_timer_core_inc_repeater.sv
// Button qualifier: one increment on the rising edge, then one per rep_pulse
// once REPEAT_DELAY strobes have been seen while the button stays held.
module inc_repeater
    import eggtimer_pkg::*;
#(
    parameter int REPEAT_DELAY = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    input  logic rep_pulse,
    output logic inc
);

    localparam int            CW   = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);

    rep_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= REP_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // REP_IDLE doubles as the edge detector: it is only occupied while level was low.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        inc       = 1'b0;
        case (state)
            REP_IDLE: begin
                if (level) begin
                    inc       = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = (REPEAT_DELAY == 0) ? REP_REPEAT : REP_HOLD;
                end
            end
            REP_HOLD: begin
                if (!level) begin
                    state_nxt = REP_IDLE;
                    cnt_nxt   = '0;
                end else if (rep_pulse) begin
                    if (cnt == LAST) begin
                        state_nxt = REP_REPEAT;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            REP_REPEAT: begin
                if (!level) begin
                    state_nxt = REP_IDLE;
                    cnt_nxt   = '0;
                end else if (rep_pulse) begin
                    inc = 1'b1;
                end
            end
            default: begin
                state_nxt = REP_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/countdown_timer_core.sv
// Egg-timer datapath: BCD MM:SS setting counters, running countdown and
// sticky done flag with a one-cycle done strobe.
module countdown_timer_core
    import eggtimer_pkg::*;
#(
    parameter int MAX_MIN      = MAX_MIN_DEFAULT,
    parameter int REPEAT_DELAY = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sec_tick,
    input  logic                  rep_pulse,
    countdown_timer_core_if.slave tmr
);

    localparam logic [BCD_W-1:0] MIN_MAX_BCD = to_bcd(MAX_MIN);

    logic             inc_sec, inc_min;
    logic [BCD_W-1:0] set_min, set_sec;
    logic [BCD_W-1:0] cur_min, cur_sec;
    logic             done_q, pulse_q;
    logic             cur_zero, done_set;

    inc_repeater #(.REPEAT_DELAY(REPEAT_DELAY)) u_rep_sec (
        .clk       (clk),
        .reset_n   (reset_n),
        .level     (tmr.increment_seconds),
        .rep_pulse (rep_pulse),
        .inc       (inc_sec)
    );

    inc_repeater #(.REPEAT_DELAY(REPEAT_DELAY)) u_rep_min (
        .clk       (clk),
        .reset_n   (reset_n),
        .level     (tmr.increment_minutes),
        .rep_pulse (rep_pulse),
        .inc       (inc_min)
    );

    // Seconds wrap without carrying into minutes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            set_min <= '0;
            set_sec <= '0;
        end else if (tmr.prog_mode) begin
            if (inc_sec) set_sec <= bcd_inc(set_sec, SEC_MAX);
            if (inc_min) set_min <= bcd_inc(set_min, MIN_MAX_BCD);
        end
    end

    assign cur_zero = (cur_min == '0) && (cur_sec == '0);
    assign done_set = cur_zero && tmr.main_timer_enable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_min <= '0;
            cur_sec <= '0;
        end else if (tmr.load_timer) begin
            cur_min <= set_min;
            cur_sec <= set_sec;
        end else if (tmr.main_timer_enable && sec_tick && !cur_zero) begin
            if (cur_sec == '0) begin
                cur_sec <= SEC_MAX;
                cur_min <= bcd_dec(cur_min);
            end else begin
                cur_sec <= bcd_dec(cur_sec);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= !tmr.load_timer && done_set && !done_q;
            if (tmr.load_timer) begin
                done_q <= 1'b0;
            end else if (done_set) begin
                done_q <= 1'b1;
            end
        end
    end

    assign tmr.timer_done = done_q;
    assign tmr.done_pulse = pulse_q;
    assign tmr.disp_min   = tmr.prog_mode ? set_min : cur_min;
    assign tmr.disp_sec   = tmr.prog_mode ? set_sec : cur_sec;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Scoreboard bench: the driver pushes reference-model predictions each cycle,
// the monitor pops and compares them against the DUT outputs.
module tb_countdown_timer_core;

    localparam int MAX_MIN      = 59;
    localparam int REPEAT_DELAY = 4;
    localparam int CYCLE_LIMIT  = 20000;

    typedef struct {
        logic [7:0] dmin;
        logic [7:0] dsec;
        logic       done;
        logic       pulse;
    } exp_t;

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic sec_tick  = 1'b0;
    logic rep_pulse = 1'b0;

    countdown_timer_core_if tif ();

    countdown_timer_core #(
        .MAX_MIN      (MAX_MIN),
        .REPEAT_DELAY (REPEAT_DELAY)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sec_tick  (sec_tick),
        .rep_pulse (rep_pulse),
        .tmr       (tif.slave)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   async_req  = 0;
    bit   stim_done  = 1'b0;

    // Reference model: setting as decimal minutes/seconds, countdown as total seconds.
    int m_smin = 0, m_ssec = 0, m_cur = 0;
    bit m_done = 0, m_pulse = 0;
    bit m_prev_s = 0, m_prev_m = 0;
    int m_hold_s = 0, m_hold_m = 0;
    bit last_rst = 0;

    function automatic logic [7:0] bcd(input int n);
        return 8'(((n / 10) * 16) + (n % 10));
    endfunction

    task automatic chan(input bit lvl, input bit rep, input bit prev, input int hold,
                        output bit inc, output int hold_o);
        inc = lvl && (!prev || (rep && hold >= REPEAT_DELAY));
        if (!lvl)                                  hold_o = 0;
        else if (prev && rep && hold < REPEAT_DELAY) hold_o = hold + 1;
        else                                       hold_o = hold;
    endtask

    // Predict the state after the coming posedge from the inputs now applied.
    task automatic cyc();
        exp_t e;
        bit   is, im, ld, en, pm;
        int   hs, hm, set_tot;
        ld = tif.load_timer;
        en = tif.main_timer_enable;
        pm = tif.prog_mode;
        if (!reset_n) begin
            if (last_rst) async_req++;
            m_smin = 0; m_ssec = 0; m_cur = 0; m_done = 0; m_pulse = 0;
            m_prev_s = 0; m_prev_m = 0; m_hold_s = 0; m_hold_m = 0;
        end else begin
            chan(tif.increment_seconds, rep_pulse, m_prev_s, m_hold_s, is, hs);
            chan(tif.increment_minutes, rep_pulse, m_prev_m, m_hold_m, im, hm);
            set_tot = m_smin * 60 + m_ssec;
            m_pulse = !ld && m_cur == 0 && en && !m_done;
            if (ld)                     m_done = 0;
            else if (m_cur == 0 && en)  m_done = 1;
            if (ld)                                   m_cur = set_tot;
            else if (en && sec_tick && m_cur > 0)     m_cur = m_cur - 1;
            if (pm && is) m_ssec = (m_ssec + 1) % 60;
            if (pm && im) m_smin = (m_smin + 1) % (MAX_MIN + 1);
            m_prev_s = tif.increment_seconds; m_hold_s = hs;
            m_prev_m = tif.increment_minutes; m_hold_m = hm;
        end
        last_rst = reset_n;
        e.dmin  = pm ? bcd(m_smin) : bcd(m_cur / 60);
        e.dsec  = pm ? bcd(m_ssec) : bcd(m_cur % 60);
        e.done  = m_done;
        e.pulse = m_pulse;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic press_sec();
        tif.increment_seconds = 1'b1; cyc();
        tif.increment_seconds = 1'b0; cyc();
    endtask

    task automatic press_min();
        tif.increment_minutes = 1'b1; cyc();
        tif.increment_minutes = 1'b0; cyc();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sec_tick = 1'b1; cyc();
            sec_tick = 1'b0; cyc();
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus
    initial begin
        tif.increment_seconds = 1'b0;
        tif.increment_minutes = 1'b0;
        tif.prog_mode         = 1'b1;
        tif.load_timer        = 1'b0;
        tif.main_timer_enable = 1'b0;
        @(negedge clk);
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();
        press_sec();                           // 00:01
        for (int i = 0; i < 58; i++) press_sec();  // 00:59
        press_sec();                           // 00:00, minutes unchanged
        for (int i = 0; i < MAX_MIN; i++) press_min();
        press_min();                           // MAX_MIN -> 00
        // Hold minutes across 8 rep_pulse strobes.
        tif.increment_minutes = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            cyc(); cyc();
            rep_pulse = 1'b1; cyc();
            rep_pulse = 1'b0;
        end
        tif.increment_minutes = 1'b0;
        cyc(); cyc();
        // Fresh 01:00 setting.
        reset_n = 1'b0; cyc();
        reset_n = 1'b1; cyc();
        press_min();
        tif.load_timer = 1'b1; cyc();
        tif.load_timer = 1'b0;
        tif.prog_mode  = 1'b0;
        tif.main_timer_enable = 1'b1;
        cyc();
        ticks(60);
        cyc(); cyc(); cyc();
        // load_timer beats a coincident sec_tick.
        tif.load_timer = 1'b1; sec_tick = 1'b1; cyc();
        tif.load_timer = 1'b0; sec_tick = 1'b0; cyc();
        ticks(30);
        // Asynchronous reset at 00:30, then enabled at 00:00 out of reset.
        reset_n = 1'b0; cyc(); cyc();
        reset_n = 1'b1; cyc(); cyc(); cyc();
        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            reset_n   = ($urandom_range(0, 599) != 0);
            rep_pulse = ($urandom_range(0, 3) == 0);
            sec_tick  = ($urandom_range(0, 2) == 0);
            tif.load_timer = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) tif.prog_mode = ~tif.prog_mode;
            if ($urandom_range(0, 49) == 0) tif.main_timer_enable = ~tif.main_timer_enable;
            if ($urandom_range(0, 5) == 0)  tif.increment_seconds = ~tif.increment_seconds;
            if ($urandom_range(0, 5) == 0)  tif.increment_minutes = ~tif.increment_minutes;
            cyc();
        end
        stim_done = 1'b1;
    end

    // Monitor
    initial begin
        exp_t e;
        int   seen = 0;
        int   cycles = 0;
        forever begin
            @(negedge clk); #2;
            if (async_req != seen) begin
                seen = async_req;
                check("async_rst_disp_min", tif.disp_min, 8'h00);
                check("async_rst_disp_sec", tif.disp_sec, 8'h00);
                check("async_rst_timer_done", {7'd0, tif.timer_done}, 8'h00);
            end
            @(posedge clk); #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("disp_min", tif.disp_min, e.dmin);
                check("disp_sec", tif.disp_sec, e.dsec);
                check("timer_done", {7'd0, tif.timer_done}, {7'd0, e.done});
                check("done_pulse", {7'd0, tif.done_pulse}, {7'd0, e.pulse});
            end else if (stim_done) begin
                break;
            end
            cycles++;
            if (cycles > CYCLE_LIMIT) begin
                checks++;
                failures++;
                $display("FAIL cycle_budget actual=%0d limit=%0d", cycles, CYCLE_LIMIT);
                break;
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
